// File: rtl/ti170_pkg.sv
// Shared TI170 types and constants for the memory-port arbiter and its helpers.
package ti170_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int N_REQ     = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_STORE = 1;
  localparam int REQ_LOAD  = 2;

  // One-hot vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot3(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters. The search starts at
// (last + 1) mod 3; winner is only meaningful while valid is high.
module rr_pick3 (
  input  logic [2:0] eligible,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  // Rotate priority so the most recent winner is served last.
  always_comb begin
    valid  = |eligible;
    winner = 2'd0;
    case (last)
      2'd0:    winner = eligible[1] ? 2'd1 : (eligible[2] ? 2'd2 : 2'd0);
      2'd1:    winner = eligible[2] ? 2'd2 : (eligible[0] ? 2'd0 : 2'd1);
      default: winner = eligible[0] ? 2'd0 : (eligible[1] ? 2'd1 : 2'd2);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the TI170 core: fetch, store and loader share
// one synchronous memory, with round-robin grant and an optional burst lock.
//
// Handshake: a requester raises req[i] with addr/we/wdata stable and holds all
// of them until done[i] pulses for one cycle; a req still high in the cycle
// after done is a new transaction. rdata is valid only while done[i] is high.
module mem_port_arbiter
  import ti170_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       rdata,
  output logic [1:0]          gnt_id,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output arb_state_t          dbg_state
);

  arb_state_t        state_q, state_d;
  logic              owner_vld_q;
  logic [1:0]        owner_id_q;
  logic [1:0]        last_q;
  logic [1:0]        gnt_q;
  logic              cur_we_q;
  logic [N_REQ-1:0]  done_q;
  logic              mem_en_q, mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;

  logic              owner_hold;
  logic [N_REQ-1:0]  eligible;
  logic [1:0]        pick_id;
  logic              pick_vld;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  // An owner keeps exclusivity only while its lock is still asserted.
  assign owner_hold = owner_vld_q & lock[owner_id_q];
  assign eligible   = owner_hold ? (req & onehot3(owner_id_q)) : req;

  rr_pick3 u_pick (
    .eligible (eligible),
    .last     (last_q),
    .winner   (pick_id),
    .valid    (pick_vld)
  );

  // Route the candidate winner's transaction fields to the capture registers.
  always_comb begin
    sel_we    = we[0];
    sel_addr  = addr[AW-1:0];
    sel_wdata = wdata[DW-1:0];
    case (pick_id)
      2'd1: begin
        sel_we    = we[1];
        sel_addr  = addr[AW +: AW];
        sel_wdata = wdata[DW +: DW];
      end
      2'd2: begin
        sel_we    = we[2];
        sel_addr  = addr[2*AW +: AW];
        sel_wdata = wdata[2*DW +: DW];
      end
      default: ;
    endcase
  end

  // Next-state logic: one grant, one memory cycle, one response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant capture, memory strobes, completion pulse and lock ownership.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_vld_q <= 1'b0;
      owner_id_q  <= 2'd0;
      last_q      <= 2'd2;
      gnt_q       <= 2'd0;
      cur_we_q    <= 1'b0;
      done_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (owner_vld_q && !lock[owner_id_q]) owner_vld_q <= 1'b0;
          if (pick_vld) begin
            gnt_q       <= pick_id;
            last_q      <= pick_id;
            cur_we_q    <= sel_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          done_q   <= onehot3(gnt_q);
        end
        RESP: begin
          done_q      <= '0;
          owner_vld_q <= lock[gnt_q];
          owner_id_q  <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign gnt_id    = gnt_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Memory data arrives in the response cycle; writes return zero.
  assign rdata     = (state_q == RESP && !cur_we_q) ? mem_rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, transaction-level reference
// model, directed scenarios and a randomized multi-requester run.
module tb_mem_port_arbiter;
  import ti170_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req = '0, we = '0, lock = '0;
  logic [23:0]   addr = '0;
  logic [23:0]   wdata = '0;
  logic [2:0]    done;
  logic [7:0]    rdata;
  logic [1:0]    gnt_id;
  logic          busy, mem_en, mem_we;
  logic [7:0]    mem_addr, mem_wdata;
  logic [7:0]    mem_rdata = '0;
  arb_state_t    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .done(done), .rdata(rdata), .gnt_id(gnt_id),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- behavioural memory macro ----------------
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      mem_ready <= 1'b1;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [256];
  int         m_phase;              // 0 waiting, 1 memory cycle, 2 response
  logic [1:0] m_last, m_gnt, m_win, m_own;
  logic       m_own_v, m_we;
  logic [7:0] m_addr, m_wdata;
  logic [9:0] exp_q[$];             // {winner, expected rdata}
  logic [1:0] grant_log[$];

  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset   = 1'b0;
    m_phase = 0; m_last = 2'd2; m_gnt = 2'd0; m_own_v = 1'b0; m_own = 2'd0;
    exp_q.delete();
    grant_log.delete();
  endtask

  // Write memory directly while the arbiter is idle with no requests.
  task automatic preset(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clock); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*8 +: 8]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  // One clock: advance the transaction-level model, then check the DUT.
  task automatic tick();
    logic [2:0] elig;
    logic       found;
    logic [9:0] e;
    int         c;
    @(posedge clock);
    case (m_phase)
      0: begin
        if (m_own_v && !lock[m_own]) m_own_v = 1'b0;
        elig  = m_own_v ? (req & (3'b001 << m_own)) : req;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = (int'(m_last) + k) % 3;
          if (!found && elig[c]) begin
            found = 1'b1;
            m_win = 2'(c);
          end
        end
        if (found) begin
          m_last  = m_win;
          m_gnt   = m_win;
          m_we    = we[m_win];
          m_addr  = addr[int'(m_win)*8 +: 8];
          m_wdata = wdata[int'(m_win)*8 +: 8];
          m_phase = 1;
          grant_log.push_back(m_win);
        end
      end
      1: begin
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
          exp_q.push_back({m_win, 8'h00});
        end else begin
          exp_q.push_back({m_win, ref_mem[m_addr]});
        end
        m_phase = 2;
      end
      default: begin
        m_own_v = lock[m_win];
        m_own   = m_win;
        m_phase = 0;
      end
    endcase
    #1;
    n_tests++;
    if (busy !== (m_phase != 0)) begin
      n_fail++; $display("FAIL busy: got %b want %b", busy, (m_phase != 0));
    end
    n_tests++;
    if (mem_en !== (m_phase == 1)) begin
      n_fail++; $display("FAIL mem_en: got %b want %b", mem_en, (m_phase == 1));
    end
    n_tests++;
    if (gnt_id !== m_gnt) begin
      n_fail++; $display("FAIL gnt_id: got %0d want %0d", gnt_id, m_gnt);
    end
    if (m_phase == 1) begin
      n_tests++;
      if (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
        n_fail++;
        $display("FAIL mem_cmd: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata);
      end
    end else begin
      n_tests++;
      if (mem_we !== 1'b0) begin
        n_fail++; $display("FAIL mem_we_idle: got %b want 0", mem_we);
      end
    end
    if (m_phase == 2) begin
      e = exp_q.pop_front();
      n_tests++;
      if (done !== (3'b001 << e[9:8]) || rdata !== e[7:0]) begin
        n_fail++;
        $display("FAIL response: got done=%b rdata=%h want done=%b rdata=%h",
                 done, rdata, (3'b001 << e[9:8]), e[7:0]);
      end
    end else begin
      n_tests++;
      if (done !== 3'b000) begin
        n_fail++; $display("FAIL done_idle: got %b want 000", done);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (done !== 3'b000 || rdata !== 8'h00 || gnt_id !== 2'd0 || busy !== 1'b0 ||
        mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got done=%b rdata=%h gnt=%0d busy=%b en=%b we=%b a=%h d=%h want all zero",
               done, rdata, gnt_id, busy, mem_en, mem_we, mem_addr, mem_wdata);
    end
    // Async reset while a read is in flight clears outputs without a clock.
    set_req(1, 1'b0, 8'h44, 8'h00);
    tick();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || gnt_id !== 2'd0 || done !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b en=%b gnt=%0d done=%b want 0 0 0 000",
               busy, mem_en, gnt_id, done);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    preset(8'h10, 8'hA5);
    set_req(0, 1'b0, 8'h10, 8'h00);
    tick();
    n_tests++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_cmd: got en=%b a=%h we=%b want 1 10 0", mem_en, mem_addr, mem_we);
    end
    tick();
    n_tests++;
    if (done !== 3'b001 || rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_read_resp: got done=%b rdata=%h want 001 a5", done, rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 8'(8'h50 + i), 8'h00);
    for (int t = 0; t < 6; t++) begin
      tick();
      n_tests++;
      if (gnt_id !== order[t] || mem_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got gnt=%0d en=%b want gnt=%0d en=1", t, gnt_id, mem_en, order[t]);
      end
      tick();
      addr[int'(order[t])*8 +: 8] = 8'(8'h60 + t);
      tick();
    end
    req = '0;
    tick();
  endtask

  task automatic test_write_then_read();
    do_reset();
    set_req(1, 1'b1, 8'hF0, 8'h3C);
    tick();
    n_tests++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_addr !== 8'hF0) begin
      n_fail++;
      $display("FAIL store_cmd: got we=%b a=%h d=%h want 1 f0 3c", mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_tests++;
    if (done !== 3'b010 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL store_resp: got done=%b rdata=%h want 010 00", done, rdata);
    end
    req = '0; we = '0;
    tick();
    set_req(0, 1'b0, 8'hF0, 8'h00);
    tick();
    tick();
    n_tests++;
    if (done !== 3'b001 || rdata !== 8'h3C) begin
      n_fail++; $display("FAIL readback: got done=%b rdata=%h want 001 3c", done, rdata);
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock_burst();
    logic [7:0] ld_data [4];
    for (int j = 0; j < 4; j++) ld_data[j] = 8'($urandom_range(0, 255));
    do_reset();
    lock[2] = 1'b1;
    set_req(2, 1'b1, 8'h00, ld_data[0]);
    for (int j = 0; j < 4; j++) begin
      tick();
      n_tests++;
      if (gnt_id !== 2'd2 || mem_en !== 1'b1) begin
        n_fail++; $display("FAIL burst_grant[%0d]: got gnt=%0d en=%b want 2 1", j, gnt_id, mem_en);
      end
      if (j == 0) set_req(0, 1'b0, 8'h03, 8'h00);
      tick();
      if (j < 3) begin
        addr[16 +: 8]  = 8'(j + 1);
        wdata[16 +: 8] = ld_data[j+1];
      end else begin
        lock[2] = 1'b0; req[2] = 1'b0; we[2] = 1'b0;
      end
      tick();
    end
    tick();
    n_tests++;
    if (gnt_id !== 2'd0 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL post_burst_grant: got gnt=%0d en=%b want 0 1", gnt_id, mem_en);
    end
    tick();
    n_tests++;
    if (rdata !== ld_data[3]) begin
      n_fail++; $display("FAIL burst_readback: got %h want %h", rdata, ld_data[3]);
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock_stall();
    do_reset();
    lock[2] = 1'b1;
    set_req(2, 1'b0, 8'h08, 8'h00);
    tick(); tick();
    req[2] = 1'b0;
    set_req(1, 1'b0, 8'h09, 8'h00);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
        n_fail++; $display("FAIL stall[%0d]: got busy=%b en=%b want 0 0", k, busy, mem_en);
      end
    end
    lock[2] = 1'b0;
    tick();
    n_tests++;
    if (gnt_id !== 2'd1 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL unlock_grant: got gnt=%0d en=%b want 1 1", gnt_id, mem_en);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    preset(8'h20, 8'h5A);
    set_req(0, 1'b1, 8'h20, 8'hC3);
    tick();
    #2 reset = 1'b1;
    req = '0; we = '0;
    #1;
    n_tests++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || done !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_write: got en=%b we=%b done=%b want 0 0 000", mem_en, mem_we, done);
    end
    @(posedge clock); #1;
    n_tests++;
    if (done !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got done=%b busy=%b want 000 0", done, busy);
    end
    do_reset();
    set_req(1, 1'b0, 8'h20, 8'h00);
    set_req(2, 1'b0, 8'h21, 8'h00);
    tick();
    n_tests++;
    if (gnt_id !== 2'd1) begin
      n_fail++; $display("FAIL first_after_reset: got %0d want 1", gnt_id);
    end
    req[2] = 1'b0;
    tick();
    n_tests++;
    if (rdata !== 8'h5A) begin
      n_fail++; $display("FAIL aborted_write_kept: got %h want 5a", rdata);
    end
    req = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [2:0] pend;
    do_reset();
    pend = '0;
    for (int cyc = 0; cyc < 450; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)));
            pend[i] = 1'b1;
            if ($urandom_range(0, 5) == 0) lock[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
          end
        end
        if (lock[i] && $urandom_range(0, 3) == 0) lock[i] = 1'b0;
      end
      tick();
      if (m_phase == 2) pend[m_win] = 1'b0;
    end
    req = '0; lock = '0;
    repeat (4) tick();
    n_tests++;
    if (grant_log.size() < 60) begin
      n_fail++; $display("FAIL random_throughput: got %0d grants want >= 60", grant_log.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_lock_burst();
    test_lock_stall();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
